ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
Upstream input stage between the board's PS/2 pins and the game-control logic that sets car position and motion for the car renderer. It synchronises ps2_clk and ps2_data into the 65 MHz domain and deframes 11-bit PS/2 device-to-host frames. It folds E0 (extended) and F0 (break) prefixes into one key event, and also keeps level-held flags for the game keys. Receive only; the host never drives the PS/2 lines.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the ps2_clk and ps2_data synchronisers (minimum 2).
TIMEOUT_CYCLES, 130000, clk cycles with no ps2_clk falling edge mid-frame before the frame is abandoned (2 ms at 65 MHz).
FILTER_LEN, 8, consecutive equal synchronised ps2_clk samples needed before the filtered clock level changes.

Ports:
clk  in  1  system clock, 65 MHz.
rst  in  1  synchronous reset, active-low (0 = reset).
ps2_clk  in  1  raw PS/2 clock, asynchronous.
ps2_data  in  1  raw PS/2 data, asynchronous.
key_code  out  8  scan code of the last completed key event.
key_ext  out  1  key_code was preceded by E0.
key_break  out  1  event is a release (preceded by F0).
key_valid  out  1  one-cycle strobe; key_code, key_ext and key_break are valid and stay held until the next strobe.
frame_err  out  1  one-cycle strobe on start, parity, stop or timeout error.
gas_held  out  1  level; space (29, not extended) is pressed.
gear_up_held  out  1  level; up arrow (E0 75) is pressed.
gear_dn_held  out  1  level; down arrow (E0 72) is pressed.

Behaviour:
- Reset (rst=0 on a clk edge): every output goes to 0. FSM goes to IDLE. Prefix flags, shift register, timeout counter and filter are cleared. The filtered clock level is set to 1. Reset mid-frame discards the partial frame without raising frame_err.
- Input path: SYNC_STAGES flops per line. The ps2_clk glitch filter follows. A falling edge is a filtered 1->0 transition and is a one-cycle internal strobe. Data is sampled from the synchronised ps2_data in that same cycle.
- Frame FSM, one step per falling edge:
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> frame_err, stay in IDLE.
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: the 8 data bits plus the parity bit must have odd parity. On failure, latch an error and continue to STOP.
  - STOP: data must be 1. If it is and there is no parity error, the byte is accepted. Otherwise frame_err. Either way -> IDLE.
- Timeout: the counter resets on every falling edge and on entry to IDLE. If it reaches TIMEOUT_CYCLES while the FSM is not IDLE: frame_err, -> IDLE, clear the prefix flags.
- Byte decoder, acting on an accepted byte:
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - Any other byte: the next cycle drives key_valid=1 with key_code=byte, key_ext=ext, key_break=brk, then clears both flags.
  - Prefixes produce no strobe. E0 F0 xx gives ext=1, brk=1.
- Latency: key_valid rises 2 clk cycles after the falling edge that samples the stop bit.
- Held flags: on a key_valid whose code/ext matches a game key, the flag is set to !key_break. Unrelated codes leave the flags unchanged. A repeated make (typematic) keeps the flag at 1.
- A frame error clears ext and brk, so a corrupted prefix cannot attach to the next key.
- A falling edge arriving in the same cycle as a timeout: the timeout wins and the edge is ignored.
- key_valid and frame_err are never both 1 in the same cycle.

Decomposition:
- Shared package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, KEY_SPACE=8'h29, KEY_UP=8'h75, KEY_DOWN=8'h72.
  - The FSM state encoding IDLE/DATA/PARITY/STOP.
- One sub-module, ps2_rx: synchroniser, filter and frame FSM. It outputs a byte and a byte_valid strobe plus an error strobe.
- ps2_keyboard wraps ps2_rx and adds the prefix decoder and held flags.

Test Plan:
- Make/break: frame 29 (odd parity correct) then F0, 29 at a 60 us bit period -> key_valid with code=29, ext=0, brk=0, gas_held=1. Then key_valid with code=29, brk=1, gas_held=0.
- Extended: E0 75 then E0 F0 75 -> gear_up_held 0->1->0. key_ext=1 on both strobes. Exactly two key_valid strobes total.
- Bad parity: send 1C with the parity bit inverted -> one frame_err strobe, no key_valid. The following good 1C frame -> key_valid with code=1C.
- Timeout: send start plus 4 data bits, then hold ps2_clk high for 2.1 ms -> frame_err about 130000 cycles after the last edge, FSM back in IDLE. A following good frame decodes normally.
- Glitch and reset: inject 3-cycle low pulses on ps2_clk mid-frame -> no extra bits shifted. Assert rst=0 mid-frame -> all outputs 0, no frame_err, and the next full frame decodes correctly.
- Prefix cleared by error: E0, then a corrupt frame, then 75 -> key_valid with code=75 and ext=0; gear_up_held stays 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan-code constants and frame FSM states for the PS/2 receiver
// Contents:
//   PS2_EXT, PS2_BRK      prefix bytes (extended, break)
//   KEY_SPACE/UP/DOWN     game-key scan codes
//   ps2_state_e           frame FSM state encoding
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 line synchroniser, clock glitch filter and 11-bit frame deframer
// Ports:
//   clk            in   system clock
//   rst            in   synchronous reset, active-low
//   ps2_clk        in   raw PS/2 clock (asynchronous)
//   ps2_data       in   raw PS/2 data (asynchronous)
//   rx_byte        out  last accepted data byte
//   rx_byte_valid  out  one-cycle strobe, rx_byte accepted
//   rx_err         out  one-cycle strobe, start/parity/stop/timeout error
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 130000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FL_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   filt_q, filt_d;
    logic [FL_W-1:0]        filt_cnt_q, filt_cnt_d;
    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   err_q, err_d;

    logic clk_s;
    logic data_s;
    logic fall;
    logic timeout;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};

        // The filtered level only follows the synchronised clock after
        // FILTER_LEN consecutive disagreeing samples; any agreeing sample
        // restarts the count, so short pulses never reach the FSM.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FL_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FL_W'(1);
            end
        end
        fall = filt_q & ~filt_d;
    end

    assign timeout = (state_q != IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;
        to_cnt_d     = (state_q == IDLE || fall) ? '0 : to_cnt_q + TO_W'(1);

        // Timeout takes priority over a coincident falling edge.
        if (timeout) begin
            err_d    = 1'b1;
            state_d  = IDLE;
            to_cnt_d = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                        par_err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_err_d = ~(^{shift_q, data_s});
                    state_d   = STOP;
                end
                STOP: begin
                    if (data_s && !par_err_q) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            par_err_q    <= 1'b0;
            to_cnt_q     <= '0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            to_cnt_q     <= to_cnt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    assign rx_byte       = byte_q;
    assign rx_byte_valid = byte_valid_q;
    assign rx_err        = err_q;

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver with prefix folding and game-key held flags
// Ports:
//   clk           in   system clock, 65 MHz
//   rst           in   synchronous reset, active-low
//   ps2_clk       in   raw PS/2 clock
//   ps2_data      in   raw PS/2 data
//   key_code      out  scan code of last key event
//   key_ext       out  event was E0-prefixed
//   key_break     out  event was F0-prefixed (release)
//   key_valid     out  one-cycle event strobe
//   frame_err     out  one-cycle frame error strobe
//   gas_held      out  space pressed
//   gear_up_held  out  up arrow pressed
//   gear_dn_held  out  down arrow pressed
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 130000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err,
    output logic       gas_held,
    output logic       gear_up_held,
    output logic       gear_dn_held
);

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_err;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .rx_err       (rx_err)
    );

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic       key_break_q, key_break_d;
    logic       key_valid_q, key_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       gas_q, gas_d;
    logic       up_q, up_d;
    logic       dn_q, dn_d;

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        key_valid_d = 1'b0;
        // Registered alongside key_valid so the two strobes share latency;
        // the receiver never raises byte_valid and err together.
        frame_err_d = rx_err;
        gas_d       = gas_q;
        up_d        = up_q;
        dn_d        = dn_q;

        if (rx_err) begin
            // Drop pending prefixes so a damaged frame cannot tag the next key.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_byte_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                key_valid_d = 1'b1;
                key_code_d  = rx_byte;
                key_ext_d   = ext_q;
                key_break_d = brk_q;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
                if (rx_byte == KEY_SPACE && !ext_q) gas_d = !brk_q;
                if (rx_byte == KEY_UP    &&  ext_q) up_d  = !brk_q;
                if (rx_byte == KEY_DOWN  &&  ext_q) dn_d  = !brk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_code_q  <= 8'd0;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            gas_q       <= 1'b0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
            gas_q       <= gas_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
        end
    end

    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign key_break    = key_break_q;
    assign key_valid    = key_valid_q;
    assign frame_err    = frame_err_q;
    assign gas_held     = gas_q;
    assign gear_up_held = up_q;
    assign gear_dn_held = dn_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - self-checking bench for ps2_keyboard with a key-event model
module tb_ps2_keyboard;

    localparam int TO = 600;
    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, frame_err;
    logic       gas_held, gear_up_held, gear_dn_held;

    ps2_keyboard #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .key_valid   (key_valid),
        .frame_err   (frame_err),
        .gas_held    (gas_held),
        .gear_up_held(gear_up_held),
        .gear_dn_held(gear_dn_held)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   kv_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   bit_half = 20;
    bit   m_ext = 0, m_brk = 0;
    bit   m_gas = 0, m_up = 0, m_dn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected outcome of one complete frame, from the keyboard protocol rules.
    task automatic model_frame(input bit [7:0] b, input bit bad);
        exp_t e;
        if (bad) begin
            e = '{is_err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0};
            exp_q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e = '{is_err: 1'b0, code: b, ext: m_ext, brk: m_brk};
            exp_q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Compare process: every strobe is matched against the model queue,
    // held flags are checked every cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            m_gas = 0;
            m_up  = 0;
            m_dn  = 0;
        end else begin
            chk("kv_fe_exclusive", {31'd0, key_valid & frame_err}, 0);
            if (key_valid) begin
                kv_cnt++;
                if (exp_q.size() == 0) begin
                    chk("key_valid_unexpected", {31'd0, key_valid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("got_key_expected_err", {31'd0, e.is_err}, 0);
                    if (!e.is_err) begin
                        chk("key_code", {24'd0, key_code}, {24'd0, e.code});
                        chk("key_ext", {31'd0, key_ext}, {31'd0, e.ext});
                        chk("key_break", {31'd0, key_break}, {31'd0, e.brk});
                        if (e.code == 8'h29 && !e.ext) m_gas = !e.brk;
                        if (e.code == 8'h75 &&  e.ext) m_up  = !e.brk;
                        if (e.code == 8'h72 &&  e.ext) m_dn  = !e.brk;
                    end
                end
            end
            if (frame_err) begin
                err_cnt++;
                if (exp_q.size() == 0) begin
                    chk("frame_err_unexpected", {31'd0, frame_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("got_err_expected_key", {31'd0, e.is_err}, 1);
                end
            end
            chk("gas_held", {31'd0, gas_held}, {31'd0, m_gas});
            chk("gear_up_held", {31'd0, gear_up_held}, {31'd0, m_up});
            chk("gear_dn_held", {31'd0, gear_dn_held}, {31'd0, m_dn});
        end
    end

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        repeat (bit_half) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (bit_half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Short low pulse on ps2_clk well inside the high phase.
    task automatic glitch();
        repeat (12) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_after);
        bit p;
        p = (~^b) ^ bad_par;
        model_frame(b, bad_par | bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(b[i]);
            if (i == glitch_after) glitch();
        end
        ps2_bit(p);
        ps2_bit(~bad_stop);
        repeat (bit_half) @(negedge clk);
    endtask

    task automatic send_good(input bit [7:0] b);
        send_frame(b, 1'b0, 1'b0, -1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, e0, c0, d;
        bit [7:0] b;
        bit bp, bs;
        int g;

        // Reset state
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_key_code", {24'd0, key_code}, 0);
        chk("rst_key_valid", {31'd0, key_valid}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_held", {29'd0, gas_held, gear_up_held, gear_dn_held}, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Make / break of space
        k0 = kv_cnt;
        send_good(8'h29);
        drain();
        chk("mk_code", {24'd0, key_code}, 32'h29);
        chk("mk_ext_brk", {30'd0, key_ext, key_break}, 0);
        chk("mk_gas", {31'd0, gas_held}, 1);
        send_good(8'hF0);
        send_good(8'h29);
        drain();
        chk("brk_break", {31'd0, key_break}, 1);
        chk("brk_gas", {31'd0, gas_held}, 0);
        chk("mkbrk_strobes", kv_cnt - k0, 2);

        // Extended up arrow
        k0 = kv_cnt;
        send_good(8'hE0);
        send_good(8'h75);
        drain();
        chk("ext_up_mk", {30'd0, gear_up_held, key_ext}, 32'h3);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        drain();
        chk("ext_up_brk", {29'd0, gear_up_held, key_ext, key_break}, 32'h3);
        chk("ext_strobes", kv_cnt - k0, 2);

        // Bad parity then good frame
        k0 = kv_cnt;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, -1);
        drain();
        chk("badpar_errs", err_cnt - e0, 1);
        chk("badpar_no_key", kv_cnt - k0, 0);
        send_good(8'h1C);
        drain();
        chk("after_badpar_code", {24'd0, key_code}, 32'h1C);

        // Timeout: start plus four data bits, then ps2_clk held high
        e0 = err_cnt;
        model_frame(8'h00, 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        c0 = cyc;
        for (int i = 0; i < TO + 300 && err_cnt == e0; i++) @(negedge clk);
        d = cyc - c0;
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_latency_in_window",
            {31'd0, (d >= TO - bit_half + 5) && (d <= TO - bit_half + 20)}, 1);
        repeat (20) @(negedge clk);
        send_good(8'h1C);
        drain();
        chk("after_timeout_code", {24'd0, key_code}, 32'h1C);

        // Glitches mid-frame
        send_frame(8'h29, 1'b0, 1'b0, 2);
        send_frame(8'h29, 1'b0, 1'b0, 5);
        drain();
        chk("glitch_code", {24'd0, key_code}, 32'h29);
        chk("glitch_gas", {31'd0, gas_held}, 1);

        // Reset mid-frame
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        rst = 1'b0;
        m_ext = 0;
        m_brk = 0;
        repeat (2) @(negedge clk);
        chk("midrst_outputs",
            {16'd0, key_code, key_ext, key_break, key_valid, frame_err, gas_held, gear_up_held, gear_dn_held, 1'b0},
            0);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        chk("midrst_no_err", err_cnt - e0, 0);
        send_good(8'hE0);
        send_good(8'h72);
        drain();
        chk("midrst_next_code", {24'd0, key_code}, 32'h72);
        chk("midrst_dn_held", {31'd0, gear_dn_held}, 1);

        // Prefix cleared by an error
        send_good(8'hE0);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        send_good(8'h75);
        drain();
        chk("pfx_clr_code", {24'd0, key_code}, 32'h75);
        chk("pfx_clr_ext", {31'd0, key_ext}, 0);
        chk("pfx_clr_up", {31'd0, gear_up_held}, 0);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h29;
                3: b = 8'h75;
                4: b = 8'h72;
                5: b = 8'h1C;
                default: b = 8'($urandom);
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 9) == 0);
            g = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
            bit_half = int'($urandom_range(14, 30));
            send_frame(b, bp, bs, g);
        end
        drain();
        bit_half = 20;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
